sram_mem_controller: RTL and testbench
======================================

// Module: sram_mem_controller
// PURPOSE
//  Sequences the ARM core's MEM-stage load/store requests onto the external 32-bit asynchronous SRAM bus.
//  The bus signals are SRAM_ADDR, SRAM_WE_N and SRAM_DQ, and the SRAM runs on a half-rate clock.
//  Each access is held stable for SRAM_LAT core cycles. The block drops ready to freeze the pipeline until the access completes.
//  It sits between the MEM stage and the SRAM model/pads.
// PARAMETERS
//  DW        32    data width, core and SRAM
//  AW        17    SRAM word-address width
//  BASE_ADDR 1024  core byte address that maps to SRAM word 0
//  SRAM_LAT  5     core cycles per SRAM access; minimum 3, so the half-rate SRAM sees at least one full edge pair
// PORTS
//  clk        in     1   core clock
//  rst        in     1   asynchronous reset, active-low
//  rd_en      in     1   load request from the MEM stage, held until ready
//  wr_en      in     1   store request from the MEM stage, held until ready
//  address    in     32  core byte address
//  wr_data    in     DW  store data
//  rd_data    out    DW  load data, valid in the cycle ready rises for a read
//  ready      out    1   0 means freeze IF/ID/EX/MEM; 1 means the request is done or there is no request
//  SRAM_ADDR  out    AW  SRAM word address
//  SRAM_WE_N  out    1   SRAM write enable, active-low
//  SRAM_DQ    inout  DW  bidirectional data; high-Z except during write ACCESS cycles
// BEHAVIOUR
//  Reset (rst=0, async):
//   - state=IDLE, cnt=0, SRAM_WE_N=1, SRAM_ADDR=0, SRAM_DQ=Z, rd_data=0.
//   - An access in flight is aborted, and WE_N goes high immediately, not at the next edge.
//  Address map:
//   - SRAM_ADDR = ((address - BASE_ADDR) >> 2)[AW-1:0], 32-bit subtraction.
//   - Addresses below BASE_ADDR or above the SRAM size wrap modulo 2^AW. No error is raised.
//   - address[1:0] is ignored; word accesses only.
//  FSM, states IDLE -> ACCESS -> DONE -> IDLE:
//   - IDLE:
//     - On rd_en|wr_en, latch address, wr_data and op, set cnt=0, go to ACCESS.
//     - If both are asserted, the write wins and the read is dropped.
//   - ACCESS:
//     - SRAM_ADDR is driven from the latched address.
//     - Write: SRAM_DQ=latched data; SRAM_WE_N=0 for cnt 0..SRAM_LAT-2 and 1 at cnt=SRAM_LAT-1 (data/address hold).
//     - Read: SRAM_DQ=Z, SRAM_WE_N=1.
//     - cnt increments each cycle. At cnt==SRAM_LAT-1, a read captures SRAM_DQ into rd_data; then go to DONE.
//   - DONE: ready=1 for exactly one cycle, then IDLE. The core advances the MEM stage on this edge.
//  ready (combinational): IDLE: ~(rd_en|wr_en); ACCESS: 0; DONE: 1.
//  Latency:
//   - Request sampled at edge N; ready=1 during the cycle after edge N+SRAM_LAT.
//   - Back-to-back requests are not overlapped: there is one IDLE cycle between accesses.
//  Other rules:
//   - rd_en/wr_en or address changing during ACCESS is ignored; the latched copies are used.
//   - rd_data holds its last loaded value until the next read completes.
// CONFIGURATION
//  SRAM_POSTED_WR_EN defined:
//   - A write in IDLE returns ready=1 in the same cycle. Data and address are latched, and the access runs in the background.
//   - Any request that arrives while a posted write is in ACCESS/DONE sees ready=0 until that write reaches IDLE.
//   - The new request is then served normally.
//   - Reads never bypass a pending posted write.
//  SRAM_POSTED_WR_EN undefined: writes stall exactly like reads, as in the FSM above.
// STRUCTURE
//  Package sram_ctrl_pkg:
//   - state enum {IDLE, ACCESS, DONE}
//   - DW, AW and BASE_ADDR defaults
//   - addr-translate function
//  Sub-module sram_ctrl_timer:
//   - cnt counter with clear/enable and last = (cnt==SRAM_LAT-1)
//   - async active-low reset
//  The top holds the FSM, the latches and the tri-state DQ driver.
// TESTING (SRAM_LAT=5, BASE_ADDR=1024)
//  1. rd_en=1, address=1024, model word0=0xDEADBEEF
//     -> ready=0 for 5 cycles, SRAM_ADDR=0, WE_N=1 throughout
//     -> ready=1 and rd_data=0xDEADBEEF in cycle 6.
//  2. wr_en=1, address=1036, wr_data=0x12345678
//     -> SRAM_ADDR=3, WE_N=0 for 4 cycles then 1, DQ=0x12345678 during ACCESS
//     -> later read of 1036 returns 0x12345678.
//  3. rd_en and wr_en both 1, address=1028, wr_data=0xA5A5A5A5
//     -> a write occurs to word 1; rd_data is unchanged.
//  4. Write 1040 then read 1040 back-to-back
//     -> read data=written value; the two accesses are separated by exactly one IDLE cycle.
//  5. rst=0 at cnt=2 of a write
//     -> WE_N=1 and DQ=Z before the next clk edge; state=IDLE; ready=~(rd_en|wr_en) after release.
//  6. SRAM_POSTED_WR_EN build: write 1024 then immediate read 1024
//     -> write ready=1 in the same cycle; read ready=0 until the write finishes plus 5 access cycles; returns the new data.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the SRAM memory controller: FSM state
// encoding, default bus sizing and the core-byte-address to SRAM-word
// translation.
package sram_ctrl_pkg;

    localparam int          DW_DEFAULT        = 32;
    localparam int          AW_DEFAULT        = 17;
    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Byte address to SRAM word index. The subtraction is plain 32-bit, so
    // addresses below the base wrap; the caller keeps only the low AW bits.
    function automatic logic [31:0] byte_to_word(input logic [31:0] address,
                                                 input logic [31:0] base);
        logic [31:0] offset;
        offset = address - base;
        return offset >> 2;
    endfunction

endpackage

// File: rtl/sram_mem_controller_if.sv
// MEM-stage request/response bundle between the core (master) and the
// SRAM controller (slave). The controller drops ready to freeze the pipe.
interface sram_mem_controller_if
    import sram_ctrl_pkg::*;
#(
    parameter int DW = DW_DEFAULT
);

    logic          rd_en;
    logic          wr_en;
    logic [31:0]   address;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          ready;

    modport master (
        output rd_en, wr_en, address, wr_data,
        input  rd_data, ready
    );

    modport slave (
        input  rd_en, wr_en, address, wr_data,
        output rd_data, ready
    );

endinterface

// File: rtl/sram_ctrl_timer.sv
// Access-cycle counter for the SRAM controller. Counts while enabled,
// returns to zero on clear, and flags the final cycle of an access.
module sram_ctrl_timer #(
    parameter int SRAM_LAT = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int CW = $clog2(SRAM_LAT);

    logic [CW-1:0] cnt;

    // Count access cycles; cleared whenever no access is in progress.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign last = (cnt == CW'(SRAM_LAT - 1));

endmodule

// File: rtl/sram_mem_controller.sv
// Sequences MEM-stage loads/stores onto a 32-bit asynchronous SRAM bus.
// Each access is held for SRAM_LAT core cycles; ready stays low until the
// access completes, followed by one DONE cycle and one IDLE cycle.
// Optional build macro SRAM_POSTED_WR_EN: writes are acknowledged in the
// request cycle and run in the background; later requests stall until the
// posted write has returned to IDLE.
module sram_mem_controller
    import sram_ctrl_pkg::*;
#(
    parameter int          DW        = DW_DEFAULT,
    parameter int          AW        = AW_DEFAULT,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
    parameter int          SRAM_LAT  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_mem_controller_if.slave mem,
    output logic [AW-1:0]        SRAM_ADDR,
    output logic                 SRAM_WE_N,
    inout  wire  [DW-1:0]        SRAM_DQ
);

    state_e        state_q;
    logic          op_wr_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wr_data_q;
    logic [DW-1:0] rd_data_q;
    logic          req;
    logic          in_access;
    logic          cnt_clr;
    logic          cnt_last;
    logic          ready_c;
`ifdef SRAM_POSTED_WR_EN
    logic          posted_q;
`endif

    assign req       = mem.rd_en | mem.wr_en;
    assign in_access = (state_q == ACCESS);
    assign cnt_clr   = ~in_access;

    sram_ctrl_timer #(
        .SRAM_LAT (SRAM_LAT)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (in_access),
        .last (cnt_last)
    );

    // FSM and request latches: capture the request in IDLE (write wins over
    // read), load rd_data on the last cycle of a read, then pass through DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            op_wr_q   <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            rd_data_q <= '0;
`ifdef SRAM_POSTED_WR_EN
            posted_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_q   <= ACCESS;
                        op_wr_q   <= mem.wr_en;
                        addr_q    <= AW'(byte_to_word(mem.address, BASE_ADDR));
                        wr_data_q <= mem.wr_data;
`ifdef SRAM_POSTED_WR_EN
                        posted_q  <= mem.wr_en;
`endif
                    end
                end
                ACCESS: begin
                    if (cnt_last) begin
                        if (!op_wr_q) begin
                            rd_data_q <= SRAM_DQ;
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ready: low while the core has to wait for an access to finish.
    always_comb begin
        // NOTE: default assignment first keeps this block free of inferred latches.
        ready_c = 1'b0;
        case (state_q)
`ifdef SRAM_POSTED_WR_EN
            IDLE:    ready_c = mem.wr_en | ~mem.rd_en;
            ACCESS:  ready_c = posted_q & ~req;
            DONE:    ready_c = ~posted_q | ~req;
`else
            IDLE:    ready_c = ~req;
            ACCESS:  ready_c = 1'b0;
            DONE:    ready_c = 1'b1;
`endif
            default: ready_c = 1'b0;
        endcase
    end

    assign mem.ready   = ready_c;
    assign mem.rd_data = rd_data_q;
    assign SRAM_ADDR   = addr_q;

    // WE_N is decoded from state so an asynchronous reset lifts it at once;
    // it rises one cycle before the access ends to hold address and data.
    assign SRAM_WE_N = ~(in_access & op_wr_q & ~cnt_last);
    assign SRAM_DQ   = (in_access & op_wr_q) ? wr_data_q : 'z;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Self-checking bench for sram_mem_controller: directed cases followed by
// randomized loads/stores, checked against a word-level memory model.
module tb_sram_mem_controller;

    localparam int          DW    = 32;
    localparam int          AW    = 17;
    localparam int          LAT   = 5;
    localparam logic [31:0] BASE  = 32'd1024;
    localparam int          WORDS = 1 << AW;
`ifdef SRAM_POSTED_WR_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    sram_mem_controller_if #(.DW(DW)) mem_if ();

    logic [AW-1:0] sram_addr;
    logic          sram_we_n;
    wire  [DW-1:0] sram_dq;
    logic          tb_oe = 1'b0;

    // SRAM array seen on the pins, and the reference memory the core expects.
    logic [DW-1:0] sram_arr [WORDS];
    logic [DW-1:0] ref_mem  [WORDS];

    logic [DW-1:0] last_rd;
    bit            exp_wr_pending;
    logic [AW-1:0] exp_wr_addr;
    logic [DW-1:0] exp_wr_data;

    int n_vec = 0;
    int n_bad = 0;

    sram_mem_controller #(
        .DW        (DW),
        .AW        (AW),
        .BASE_ADDR (BASE),
        .SRAM_LAT  (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem       (mem_if),
        .SRAM_ADDR (sram_addr),
        .SRAM_WE_N (sram_we_n),
        .SRAM_DQ   (sram_dq)
    );

    always #5 clk = ~clk;

    assign sram_dq = tb_oe ? sram_arr[sram_addr] : 'z;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int unsigned i);
        return (i * 32'h9E3779B9) ^ 32'hC0FFEE00;
    endfunction

    // Word index from byte address: subtract base modulo 2^32, divide by 4,
    // reduce modulo the SRAM size.
    function automatic int unsigned ref_word(input logic [31:0] a);
        longint unsigned du;
        longint unsigned d;
        du = a;
        d  = (du + 64'd4294967296 - 64'd1024) % 64'd4294967296;
        return int'((d / 4) % WORDS);
    endfunction

    // Pin-level SRAM: a write lands on the rising edge of WE_N.
    always @(posedge sram_we_n) begin
        if (rst) begin
            check("wr_expected", exp_wr_pending, 1);
            check("wr_addr", sram_addr, exp_wr_addr);
            check("wr_data", sram_dq, exp_wr_data);
            sram_arr[sram_addr] = sram_dq;
            exp_wr_pending = 1'b0;
        end
    end

    task automatic idle_cycle();
        @(negedge clk);
        check("idle_ready", mem_if.ready, 1);
        check("idle_we_n", sram_we_n, 1);
        @(posedge clk); #1;
    endtask

    // One request from the core, checked cycle by cycle. Entered and left
    // just after a rising edge with the controller in IDLE.
    task automatic run_access(input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [31:0] data);
        bit            is_posted;
        int unsigned   w;
        logic [DW-1:0] exp_rd;
        is_posted = POSTED && wr;
        w = ref_word(addr);
        mem_if.rd_en   = rd;
        mem_if.wr_en   = wr;
        mem_if.address = addr;
        mem_if.wr_data = data;
        tb_oe = !wr;
        if (wr) begin
            exp_wr_pending = 1'b1;
            exp_wr_addr    = AW'(w);
            exp_wr_data    = data;
        end
        @(negedge clk);
        check("req_ready", mem_if.ready, is_posted);
        check("req_we_n", sram_we_n, 1);
        @(posedge clk); #1;
        if (is_posted) begin
            mem_if.rd_en = 1'b0;
            mem_if.wr_en = 1'b0;
        end
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            check("acc_ready", mem_if.ready, is_posted);
            check("acc_addr", sram_addr, w);
            check("acc_we_n", sram_we_n, (wr && k < LAT - 1) ? 1'b0 : 1'b1);
            check("acc_rd_hold", mem_if.rd_data, last_rd);
            if (wr) check("acc_dq", sram_dq, data);
            @(posedge clk); #1;
        end
        exp_rd = wr ? last_rd : ref_mem[w];
        @(negedge clk);
        check("done_ready", mem_if.ready, 1);
        check("done_we_n", sram_we_n, 1);
        check("done_rd_data", mem_if.rd_data, exp_rd);
        last_rd = exp_rd;
        if (wr) ref_mem[w] = data;
        @(posedge clk); #1;
        mem_if.rd_en = 1'b0;
        mem_if.wr_en = 1'b0;
        tb_oe = 1'b0;
        check("wr_landed", exp_wr_pending, 0);
    endtask

    // Asynchronous reset in the middle of a write (cnt == 2).
    task automatic reset_abort();
        mem_if.wr_en   = 1'b1;
        mem_if.address = BASE + 32'd400;
        mem_if.wr_data = 32'h7777_0000;
        @(posedge clk); #1;
        if (POSTED) mem_if.wr_en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_we_n_pre", sram_we_n, 0);
        rst = 1'b0;
        #1;
        check("abort_we_n", sram_we_n, 1);
        check("abort_addr", sram_addr, 0);
        check("abort_rd_data", mem_if.rd_data, 0);
        check("abort_ready", mem_if.ready, !(mem_if.rd_en | mem_if.wr_en));
        mem_if.wr_en   = 1'b0;
        last_rd        = '0;
        exp_wr_pending = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        idle_cycle();
    endtask

`ifdef SRAM_POSTED_WR_EN
    // Posted write to word 0 immediately followed by a read of the same word.
    task automatic posted_overlap();
        logic [DW-1:0] d;
        int            stall;
        bit            seen;
        d     = 32'hFEED_0001;
        stall = 0;
        seen  = 1'b0;
        mem_if.wr_en   = 1'b1;
        mem_if.address = BASE;
        mem_if.wr_data = d;
        exp_wr_pending = 1'b1;
        exp_wr_addr    = '0;
        exp_wr_data    = d;
        @(negedge clk);
        check("pw_ready", mem_if.ready, 1);
        @(posedge clk); #1;
        mem_if.wr_en = 1'b0;
        mem_if.rd_en = 1'b1;
        ref_mem[0]   = d;
        for (int c = 0; c < 4 * LAT + 8 && !seen; c++) begin
            @(negedge clk);
            if (mem_if.ready) begin
                seen = 1'b1;
            end else begin
                stall++;
                if (stall == LAT + 1) tb_oe = 1'b1;
            end
        end
        check("pw_stall", stall, 2 * LAT + 2);
        check("pw_rd_data", mem_if.rd_data, d);
        last_rd = d;
        @(posedge clk); #1;
        mem_if.rd_en = 1'b0;
        tb_oe = 1'b0;
        check("pw_wr_landed", exp_wr_pending, 0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mem_if.rd_en   = 1'b0;
        mem_if.wr_en   = 1'b0;
        mem_if.address = '0;
        mem_if.wr_data = '0;
        last_rd        = '0;
        exp_wr_pending = 1'b0;
        exp_wr_addr    = '0;
        exp_wr_data    = '0;
        for (int i = 0; i < WORDS; i++) begin
            sram_arr[i] = init_word(i);
            ref_mem[i]  = init_word(i);
        end
        sram_arr[0] = 32'hDEADBEEF;
        ref_mem[0]  = 32'hDEADBEEF;

        #3;
        check("rst_ready", mem_if.ready, 1);
        check("rst_we_n", sram_we_n, 1);
        check("rst_addr", sram_addr, 0);
        check("rst_rd_data", mem_if.rd_data, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        idle_cycle();

        // Read of word 0.
        run_access(1'b1, 1'b0, BASE, 32'h0);
        idle_cycle();
        // Write of word 3, read back later.
        run_access(1'b0, 1'b1, BASE + 32'd12, 32'h12345678);
        // Read and write together: the write wins, rd_data keeps its value.
        run_access(1'b1, 1'b1, BASE + 32'd4, 32'hA5A5A5A5);
        idle_cycle();
        run_access(1'b1, 1'b0, BASE + 32'd12, 32'h0);
        run_access(1'b1, 1'b0, BASE + 32'd4, 32'h0);
        // Back-to-back write then read of word 4.
        run_access(1'b0, 1'b1, BASE + 32'd16, 32'h0BADF00D);
        run_access(1'b1, 1'b0, BASE + 32'd16, 32'h0);
        // Reset in the middle of a write.
        reset_abort();
`ifdef SRAM_POSTED_WR_EN
        posted_overlap();
`endif

        for (int i = 0; i < 40; i++) begin
            int unsigned kind;
            logic [31:0] a;
            bit          rd;
            bit          wr;
            kind = $urandom_range(0, 8);
            rd   = (kind <= 3) || (kind == 8);
            wr   = (kind >= 4);
            if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 1023);
            else a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
            run_access(rd, wr, a, $urandom);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
